// File: rtl/simple_dp_mem_pkg.sv
// Shared types and sizes for the dual-port memory and its stream reader.
// Reader FSM states live here so the bench and RTL agree on names.
package simple_dp_mem_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int LEN_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage

// File: rtl/reader_skid_buf.sv
// Two-entry output buffer for the stream reader.
// Entry e0 is always the head word presented on out_dat.
module reader_skid_buf #(
    parameter int DATA_W = simple_dp_mem_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] e0_q;
    logic [DATA_W-1:0] e1_q;
    logic [1:0]        cnt_q;

    // Shift/fill the two entries; head only moves on pop or fill-from-empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            cnt_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) e0_q <= din;
                    else               e1_q <= din;
                    cnt_q <= cnt_q + 2'd1;
                end
                2'b01: begin
                    e0_q  <= e1_q;
                    cnt_q <= cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd2) begin
                        e0_q <= e1_q;
                        e1_q <= din;
                    end else begin
                        e0_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_dat   = e0_q;
    assign out_valid = (cnt_q != 2'd0);
    assign count     = cnt_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: walks simple_dp_mem from base_adr for length words
// and streams them out through a 2-entry valid/ready buffer.
module mem_stream_reader #(
    parameter int DATA_W = simple_dp_mem_pkg::DATA_W,
    parameter int ADDR_W = simple_dp_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_adr,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [DATA_W-1:0] mem_dat,
    output logic [DATA_W-1:0] out_dat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    import simple_dp_mem_pkg::*;

    localparam int CNT_W = ADDR_W + 1;

    rd_state_e         state_q;
    rd_state_e         state_d;
    logic [CNT_W-1:0]  remain_q;
    logic [ADDR_W-1:0] rd_adr_q;
    logic              inflight_q;
    logic              done_q;
    logic [1:0]        buf_cnt;
    logic [1:0]        occ;
    logic              pop;
    logic              issue;
    logic              accept;
    logic              zero_start;
    logic              last_xfer;

    assign pop        = out_valid & out_ready;
    assign accept     = (state_q == ST_IDLE) & start & (length != '0);
    assign zero_start = (state_q == ST_IDLE) & start & (length == '0);

    // Occupancy counts the word leaving this edge as already gone,
    // which keeps the pipe full at one word per clock.
    assign occ   = buf_cnt + {1'b0, inflight_q} - {1'b0, pop};
    assign issue = (state_q == ST_RUN) & (remain_q != '0)
                 & (occ < 2'd2);

    assign last_xfer = (state_q == ST_DRAIN) & pop & ~inflight_q
                     & (buf_cnt == 2'd1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_RUN;
            ST_RUN:   if (issue && remain_q == CNT_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN: if (last_xfer) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    // Address, remaining count, in-flight read and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_adr_q   <= '0;
            remain_q   <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            inflight_q <= issue;
            done_q     <= zero_start | last_xfer;
            if (accept) begin
                rd_adr_q <= base_adr;
                remain_q <= length;
            end else if (issue) begin
                rd_adr_q <= rd_adr_q + ADDR_W'(1);
                remain_q <= remain_q - CNT_W'(1);
            end
        end
    end

    assign rd_adr = rd_adr_q;
    assign done   = done_q;

    reader_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .din       (mem_dat),
        .pop       (pop),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .count     (buf_cnt)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Self-checking bench for mem_stream_reader with a behavioural memory
// and a queue-based model of the expected word stream.
module tb_mem_stream_reader;

    localparam int AW = 10;
    localparam int DW = 16;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_adr = '0;
    logic [AW:0]   length = '0;
    logic [AW-1:0] rd_adr;
    logic [DW-1:0] mem_dat;
    logic [DW-1:0] out_dat;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [0:DEPTH-1];

    int n_run = 0;
    int n_fail = 0;

    int got[$];
    int got_cyc[$];
    int done_cnt;
    int done_cyc;
    int first_valid;
    int busy_err;
    int stab_err;

    mem_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_adr  (base_adr),
        .length    (length),
        .rd_adr    (rd_adr),
        .mem_dat   (mem_dat),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_dat <= mem[rd_adr];

    function automatic int exp_word(input int b, input int k);
        return int'(mem[(b + k) % DEPTH]);
    endfunction

    // mode 0: ready always, 1: toggle 1/0, 2: random (mostly ready)
    task automatic run_burst(input int b, input int n, input int mode,
                             input int inj_at, input int inj_b,
                             input int inj_n);
        bit            prev_hold;
        logic [DW-1:0] prev_dat;
        int            post;
        int            budget;
        got.delete();
        got_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_valid = -1;
        busy_err = 0;
        stab_err = 0;
        prev_hold = 0;
        prev_dat = '0;
        post = 0;
        budget = 3 * n + 40;
        start = 1'b1;
        base_adr = AW'(b);
        length = (AW+1)'(n);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (i % 2 == 0);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (i == inj_at) begin
                start = 1'b1;
                base_adr = AW'(inj_b);
                length = (AW+1)'(inj_n);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (prev_hold && (!out_valid || out_dat !== prev_dat))
                stab_err++;
            if (out_valid && first_valid < 0) first_valid = i;
            if (busy !== (got.size() < n)) busy_err++;
            if (done) begin
                done_cnt++;
                done_cyc = i;
            end
            if (out_valid && out_ready) begin
                got.push_back(int'(out_dat));
                got_cyc.push_back(i);
            end
            prev_hold = out_valid && !out_ready;
            prev_dat = out_dat;
            @(posedge clk); #1;
            if (done_cyc >= 0) post++;
            if (post > 4) break;
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_busy: got %b want 0", busy);
        end
        n_run++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL rst_done: got %b want 0", done);
        end
        n_run++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid);
        end
        n_run++;
        if (out_dat !== '0) begin
            n_fail++; $display("FAIL rst_dat: got %h want 0", out_dat);
        end
        n_run++;
        if (rd_adr !== '0) begin
            n_fail++; $display("FAIL rst_adr: got %h want 0", rd_adr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_run++;
        if ({busy, done, out_valid} !== 3'b000 || rd_adr !== '0) begin
            n_fail++;
            $display("FAIL post_rst_idle: got b%b d%b v%b a%h want 0",
                     busy, done, out_valid, rd_adr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_wrap;
        run_burst(12'h3FE, 4, 0, -1, 0, 0);
        n_run++;
        if (got.size() != 4) begin
            n_fail++; $display("FAIL wrap_count: got %0d want 4", got.size());
        end
        for (int k = 0; k < got.size() && k < 4; k++) begin
            n_run++;
            if (got[k] != exp_word(12'h3FE, k) || got_cyc[k] != 2 + k) begin
                n_fail++;
                $display("FAIL wrap_word[%0d]: got %h@%0d want %h@%0d",
                         k, got[k], got_cyc[k], exp_word(12'h3FE, k), 2 + k);
            end
        end
        n_run++;
        if (done_cnt != 1 || done_cyc != 6) begin
            n_fail++;
            $display("FAIL wrap_done: got %0d pulses @%0d want 1 @6",
                     done_cnt, done_cyc);
        end
        n_run++;
        if (busy_err != 0) begin
            n_fail++; $display("FAIL wrap_busy: got %0d errs want 0", busy_err);
        end
    endtask

    task automatic test_backpressure;
        run_burst(12'h010, 8, 1, -1, 0, 0);
        n_run++;
        if (got.size() != 8) begin
            n_fail++; $display("FAIL bp_count: got %0d want 8", got.size());
        end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            n_run++;
            if (got[k] != exp_word(12'h010, k)) begin
                n_fail++;
                $display("FAIL bp_word[%0d]: got %h want %h",
                         k, got[k], exp_word(12'h010, k));
            end
        end
        n_run++;
        if (stab_err != 0) begin
            n_fail++; $display("FAIL bp_stable: got %0d errs want 0", stab_err);
        end
        n_run++;
        if (done_cnt != 1 || busy_err != 0) begin
            n_fail++;
            $display("FAIL bp_done_busy: got %0d/%0d want 1/0",
                     done_cnt, busy_err);
        end
    endtask

    task automatic test_zero_len;
        int bad;
        bad = 0;
        start = 1'b1;
        base_adr = AW'(12'h055);
        length = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        n_run++;
        if ({done, busy, out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_pulse: got d%b b%b v%b want d1 b0 v0",
                     done, busy, out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if ({done, busy, out_valid} !== 3'b000) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL zero_after: got %0d errs want 0", bad);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_ignore_start;
        run_burst(12'h020, 12, 1, 3, 12'h200, 5);
        n_run++;
        if (got.size() != 12) begin
            n_fail++; $display("FAIL ign_count: got %0d want 12", got.size());
        end
        for (int k = 0; k < got.size() && k < 12; k++) begin
            n_run++;
            if (got[k] != exp_word(12'h020, k)) begin
                n_fail++;
                $display("FAIL ign_word[%0d]: got %h want %h",
                         k, got[k], exp_word(12'h020, k));
            end
        end
        n_run++;
        if (done_cnt != 1 || busy_err != 0) begin
            n_fail++;
            $display("FAIL ign_done_busy: got %0d/%0d want 1/0",
                     done_cnt, busy_err);
        end
    endtask

    task automatic test_reset_mid;
        int xfers;
        int bad;
        xfers = 0;
        bad = 0;
        start = 1'b1;
        base_adr = AW'(12'h050);
        length = 11'd10;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && xfers < 3; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) xfers++;
            @(posedge clk); #1;
        end
        n_run++;
        if (xfers != 3) begin
            n_fail++; $display("FAIL mid_reach3: got %0d want 3", xfers);
        end
        rst_n = 1'b0;
        #1;
        n_run++;
        if ({busy, done, out_valid} !== 3'b000 || out_dat !== '0
            || rd_adr !== '0) begin
            n_fail++;
            $display("FAIL mid_rst_out: got b%b d%b v%b %h a%h want 0",
                     busy, done, out_valid, out_dat, rd_adr);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if ({busy, done, out_valid} !== 3'b000) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL mid_quiet: got %0d errs want 0", bad);
        end
        @(posedge clk); #1;
        run_burst(12'h100, 2, 0, -1, 0, 0);
        n_run++;
        if (got.size() != 2 || got[0] != exp_word(12'h100, 0)
            || got[1] != exp_word(12'h100, 1)) begin
            n_fail++;
            $display("FAIL mid_new_burst: got %0d words want 0100,0101",
                     got.size());
        end
        n_run++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL mid_done: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_full;
        int bad;
        bad = 0;
        run_burst(0, 1024, 0, -1, 0, 0);
        n_run++;
        if (got.size() != 1024) begin
            n_fail++; $display("FAIL full_count: got %0d want 1024", got.size());
        end
        n_run++;
        if (first_valid != 2) begin
            n_fail++; $display("FAIL full_latency: got %0d want 2", first_valid);
        end
        for (int k = 0; k < got.size(); k++)
            if (got[k] != exp_word(0, k) || got_cyc[k] != 2 + k) bad++;
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL full_stream: got %0d bad words want 0", bad);
        end
        n_run++;
        if (done_cnt != 1 || done_cyc != 1026) begin
            n_fail++;
            $display("FAIL full_done: got %0d @%0d want 1 @1026",
                     done_cnt, done_cyc);
        end
    endtask

    task automatic test_random;
        int b;
        int n;
        int bad;
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'($urandom);
        for (int it = 0; it < 8; it++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 48);
            bad = 0;
            run_burst(b, n, 2, -1, 0, 0);
            n_run++;
            if (got.size() != n) begin
                n_fail++;
                $display("FAIL rnd%0d_count: got %0d want %0d",
                         it, got.size(), n);
            end
            for (int k = 0; k < got.size(); k++)
                if (got[k] != exp_word(b, k)) bad++;
            n_run++;
            if (bad != 0 || stab_err != 0 || busy_err != 0 || done_cnt != 1)
            begin
                n_fail++;
                $display("FAIL rnd%0d: got bad%0d stab%0d busy%0d done%0d want 0/0/0/1",
                         it, bad, stab_err, busy_err, done_cnt);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < DEPTH; a++) mem[a] = DW'(a);
        test_reset();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_ignore_start();
        test_reset_mid();
        test_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 Parameter DATA_W, default 16, word width; matches simple_dp_mem dat_in/dat_out.
REQ-002 Parameter ADDR_W, default 10, address width; matches simple_dp_mem wr_adr/rd_adr.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle request to begin a burst; sampled only when busy=0.
REQ-006 base_adr  input  ADDR_W  first word address; captured when start is accepted.
REQ-007 length  input  ADDR_W+1  word count, 0..1024; captured when start is accepted.
REQ-008 rd_adr  output  ADDR_W  read address to simple_dp_mem rd_adr.
REQ-009 mem_dat  input  DATA_W  from simple_dp_mem dat_out; valid one clock after rd_adr is sampled.
REQ-010 out_dat  output  DATA_W  streamed word.
REQ-011 out_valid  output  1  out_dat holds a valid word.
REQ-012 out_ready  input  1  sink accepts; a transfer occurs on any edge with out_valid=1 and out_ready=1.
REQ-013 busy  output  1  burst in progress.
REQ-014 done  output  1  one-cycle pulse at burst end.

Function
REQ-015 FSM states: IDLE, RUN, DRAIN; reset state IDLE.
REQ-016 IDLE->RUN on start=1 with length>0; base_adr and length captured on that edge.
REQ-017 start with length=0: IDLE stays, done pulses for one cycle on the next edge, and no word is issued.
REQ-018 start while busy=1: ignored, no effect on the burst in progress or on the captured parameters.
REQ-019 busy=1 from the edge after start is accepted until the last transfer; busy=0 and done=1 for exactly the one cycle after the last transfer.
REQ-020 Read issue: one read per clock, only while the remaining count is >0 and in-flight reads plus buffered words are <2.
REQ-021 rd_adr advances by 1 per issued read and wraps modulo 2^ADDR_W (1023->0).
REQ-022 rd_adr holds its value when no read issues.
REQ-023 RUN->DRAIN when the last read issues; DRAIN->IDLE on the last transfer.
REQ-024 mem_dat captured into a 2-entry output buffer exactly one clock after each issued read; no word is dropped or duplicated under any out_ready pattern.
REQ-025 Latency: with out_ready=1, first out_valid=1 two clocks after the start edge.
REQ-026 Throughput: with out_ready=1, one word per clock for the entire burst, with no bubbles.
REQ-027 out_dat and out_valid are stable while out_valid=1 and out_ready=0.
REQ-028 Words are delivered in address order; word k is the memory content at (base_adr+k) mod 2^ADDR_W.
REQ-029 Internal count is ADDR_W+1 bits wide; length=1024 reads all addresses exactly once.

Reset
REQ-030 rst_n=0 asynchronously forces IDLE, busy=0, done=0, out_valid=0, out_dat=0, rd_adr=0, an empty buffer, and zero counts.
REQ-031 Reset mid-burst abandons the burst; no done pulse is generated and no transfer occurs until a new start.
REQ-032 Leaving reset, outputs hold their reset values until a start is accepted.

Structure
REQ-033 Shared package simple_dp_mem_pkg holds DATA_W, ADDR_W, LEN_W=ADDR_W+1 and the reader state enum.
REQ-034 One sub-module, reader_skid_buf: a 2-entry valid/ready buffer with count, push from the memory capture, and pop on transfer.

Verification
REQ-035 Memory preloaded with mem[a]=a; base=0x3FE, length=4, out_ready=1 -> out_dat 0x3FE, 0x3FF, 0x000, 0x001 on consecutive cycles; done pulses once.
REQ-036 base=0x010, length=8, out_ready toggling 1/0 every cycle -> exactly 8 words 0x010..0x017 in order, and out_dat is stable whenever out_ready=0.
REQ-037 length=0 start -> done pulses one cycle later, busy stays 0, out_valid stays 0.
REQ-038 Second start pulse mid-burst with different base and length -> ignored; the original burst completes unchanged.
REQ-039 rst_n low after the 3rd transfer of a 10-word burst -> all outputs return to reset values immediately; a new burst with base=0x100 and length=2 then delivers 0x100, 0x101.
REQ-040 length=1024, base=0 -> 1024 words on 1024 consecutive cycles, first out_valid 2 clocks after start.
